// File: rtl/flash_dma_mc.sv
// Multi-channel flash-to-PSRAM copier: NUM_CH queued descriptors served round-robin
// over one flash read port and one PSRAM write port, with replicate/pack modes and abort.
module flash_dma_mc #(
  parameter int NUM_CH   = 2,
  parameter int FLASH_AW = 24,
  parameter int PSRAM_AW = 22,
  parameter int LEN_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          ch_start,
  input  logic [NUM_CH*FLASH_AW-1:0] ch_flash_src,
  input  logic [NUM_CH*PSRAM_AW-1:0] ch_psram_dst,
  input  logic [NUM_CH*LEN_W-1:0]    ch_length,
  input  logic [NUM_CH-1:0]          ch_pack,
  input  logic                       abort,
  output logic [NUM_CH-1:0]          ch_pending,
  output logic [NUM_CH-1:0]          ch_done,
  output logic                       busy,
  output logic [2:0]                 active_ch,
  output logic                       flash_dma_enabled,
  output logic [FLASH_AW-1:0]        flash_addr,
  output logic                       flash_req_r_addr,
  output logic                       flash_req_r_next,
  input  logic                       flash_d_ready,
  input  logic [7:0]                 flash_d_out,
  output logic                       psram_w_strobe,
  output logic [PSRAM_AW-1:0]        psram_addr,
  output logic [15:0]                psram_d_in,
  input  logic                       psram_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_F_LOW, S_F_DATA, S_WR, S_ACK, S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [NUM_CH-1:0]   done_q, done_d;
  logic [2:0]          rr_ptr_q, rr_ptr_d;
  logic [2:0]          active_q, active_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [7:0]          lo_q, lo_d, hi_q, hi_d;
  logic                have_lo_q, have_lo_d;
  logic                wrote_q, wrote_d;
  logic                aborted_q, aborted_d;
  logic                en_q, en_d;
  logic [FLASH_AW-1:0] faddr_q, faddr_d;
  logic                raddr_q, raddr_d;
  logic                rnext_q, rnext_d;
  logic                strobe_q, strobe_d;
  logic [PSRAM_AW-1:0] paddr_q, paddr_d;
  logic [15:0]         pdin_q, pdin_d;

  logic [FLASH_AW-1:0] desc_src [NUM_CH];
  logic [PSRAM_AW-1:0] desc_dst [NUM_CH];
  logic [LEN_W-1:0]    desc_len [NUM_CH];
  logic [NUM_CH-1:0]   desc_pack;
  logic [NUM_CH-1:0]   accept;

  assign accept = ch_start & ~pending_q & {NUM_CH{~abort}};

  // NOTE: descriptor storage carries no reset; a slot is only read while its pending bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept[i]) begin
        desc_src[i]  <= ch_flash_src[i*FLASH_AW +: FLASH_AW];
        desc_dst[i]  <= ch_psram_dst[i*PSRAM_AW +: PSRAM_AW];
        desc_len[i]  <= ch_length[i*LEN_W +: LEN_W];
        desc_pack[i] <= ch_pack[i];
      end
    end
  end

  // Descriptor of the channel currently being served, plus its one-hot mask.
  logic [NUM_CH-1:0]   active_oh;
  logic [FLASH_AW-1:0] cur_src;
  logic [PSRAM_AW-1:0] cur_dst;
  logic [LEN_W-1:0]    cur_len;
  logic                cur_pack;

  always_comb begin
    active_oh = '0;
    cur_src   = '0;
    cur_dst   = '0;
    cur_len   = '0;
    cur_pack  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (active_q == 3'(i)) begin
        active_oh[i] = 1'b1;
        cur_src      = desc_src[i];
        cur_dst      = desc_dst[i];
        cur_len      = desc_len[i];
        cur_pack     = desc_pack[i];
      end
    end
  end

  // Round-robin pick: lowest pending index at or above the pointer, else lowest overall.
  logic       found_hi;
  logic [2:0] idx_hi, idx_any, pick_idx, ptr_next;

  always_comb begin
    found_hi = 1'b0;
    idx_hi   = '0;
    idx_any  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending_q[i] && (3'(i) >= rr_ptr_q)) begin
        found_hi = 1'b1;
        idx_hi   = 3'(i);
      end
      if (pending_q[i]) idx_any = 3'(i);
    end
    pick_idx = found_hi ? idx_hi : idx_any;
    ptr_next = (active_q == 3'(NUM_CH - 1)) ? 3'd0 : active_q + 3'd1;
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | accept;
    done_d    = '0;
    rr_ptr_d  = rr_ptr_q;
    active_d  = active_q;
    rem_d     = rem_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    have_lo_d = have_lo_q;
    wrote_d   = wrote_q;
    aborted_d = aborted_q;
    en_d      = en_q;
    faddr_d   = faddr_q;
    raddr_d   = 1'b0;
    rnext_d   = 1'b0;
    strobe_d  = 1'b0;
    paddr_d   = paddr_q;
    pdin_d    = pdin_q;

    unique case (state_q)
      S_IDLE: begin
        if (pending_q != '0) begin
          active_d = pick_idx;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (cur_len == '0) begin
          pending_d = pending_d & ~active_oh;
          done_d    = active_oh;
          rr_ptr_d  = ptr_next;
          active_d  = '0;
          state_d   = S_IDLE;
        end else begin
          en_d      = 1'b1;
          faddr_d   = cur_src;
          raddr_d   = 1'b1;
          paddr_d   = cur_dst - PSRAM_AW'(1);
          rem_d     = cur_len;
          have_lo_d = 1'b0;
          wrote_d   = 1'b0;
          aborted_d = 1'b0;
          state_d   = S_F_LOW;
        end
      end
      S_F_LOW: begin
        if (!flash_d_ready) state_d = S_F_DATA;
      end
      S_F_DATA: begin
        if (flash_d_ready) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_d != '0) rnext_d = 1'b1;
          if (cur_pack && !have_lo_q) begin
            // Low half first; the high half stays zero if this turns out to be the last byte.
            lo_d      = flash_d_out;
            hi_d      = 8'h00;
            have_lo_d = 1'b1;
            state_d   = (rem_d == '0) ? S_WR : S_F_LOW;
          end else if (cur_pack) begin
            hi_d    = flash_d_out;
            state_d = S_WR;
          end else begin
            lo_d    = flash_d_out;
            hi_d    = flash_d_out;
            state_d = S_WR;
          end
        end
      end
      S_WR: begin
        if (!psram_busy) begin
          pdin_d    = {hi_q, lo_q};
          paddr_d   = paddr_q + PSRAM_AW'(1);
          strobe_d  = 1'b1;
          wrote_d   = 1'b1;
          have_lo_d = 1'b0;
          state_d   = S_ACK;
        end
      end
      S_ACK: begin
        if (psram_busy) state_d = (rem_q != '0) ? S_F_LOW : S_DRAIN;
      end
      S_DRAIN: begin
        if (!psram_busy) begin
          if (!aborted_q) begin
            pending_d = pending_d & ~active_oh;
            done_d    = active_oh;
          end
          rr_ptr_d = ptr_next;
          en_d     = 1'b0;
          active_d = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything; a write already handed to the PSRAM is allowed to settle.
    if (abort) begin
      pending_d = '0;
      done_d    = '0;
      raddr_d   = 1'b0;
      rnext_d   = 1'b0;
      strobe_d  = 1'b0;
      faddr_d   = faddr_q;
      paddr_d   = paddr_q;
      pdin_d    = pdin_q;
      if ((state_q == S_WR && wrote_q) || state_q == S_ACK) begin
        aborted_d = 1'b1;
        en_d      = en_q;
        active_d  = active_q;
        state_d   = S_DRAIN;
      end else begin
        en_d     = 1'b0;
        active_d = '0;
        state_d  = S_IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      done_q    <= '0;
      rr_ptr_q  <= '0;
      active_q  <= '0;
      rem_q     <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      have_lo_q <= 1'b0;
      wrote_q   <= 1'b0;
      aborted_q <= 1'b0;
      en_q      <= 1'b0;
      faddr_q   <= '0;
      raddr_q   <= 1'b0;
      rnext_q   <= 1'b0;
      strobe_q  <= 1'b0;
      paddr_q   <= '0;
      pdin_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      rr_ptr_q  <= rr_ptr_d;
      active_q  <= active_d;
      rem_q     <= rem_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      have_lo_q <= have_lo_d;
      wrote_q   <= wrote_d;
      aborted_q <= aborted_d;
      en_q      <= en_d;
      faddr_q   <= faddr_d;
      raddr_q   <= raddr_d;
      rnext_q   <= rnext_d;
      strobe_q  <= strobe_d;
      paddr_q   <= paddr_d;
      pdin_q    <= pdin_d;
    end
  end

  assign ch_pending        = pending_q;
  assign ch_done           = done_q;
  assign busy              = (pending_q != '0) || (state_q != S_IDLE);
  assign active_ch         = active_q;
  assign flash_dma_enabled = en_q;
  assign flash_addr        = faddr_q;
  assign flash_req_r_addr  = raddr_q;
  assign flash_req_r_next  = rnext_q;
  assign psram_w_strobe    = strobe_q;
  assign psram_addr        = paddr_q;
  assign psram_d_in        = pdin_q;

endmodule

// File: doc/flash_dma_mc.md
Name: flash_dma_mc

Overview:
- Multi-channel, parametrised successor to the single-shot flash-to-PSRAM copier.
- Each of NUM_CH channels holds one queued descriptor: flash source, PSRAM destination, length, pack mode.
- A round-robin arbiter serialises channels onto the single flash read port and single PSRAM write port.
- Sits between the startup ROM-mirroring sequencer and the flash/PSRAM controllers.
- Adds a packed 2-bytes-per-word mode, per-channel done pulses, zero-length handling and abort.

Parameters:
- NUM_CH, 2, number of descriptor channels (1..8).
- FLASH_AW, 24, flash byte-address width.
- PSRAM_AW, 22, PSRAM word-address width.
- LEN_W, 16, byte-count width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ch_start  in  NUM_CH  per-channel one-cycle start request.
- ch_flash_src  in  NUM_CH*FLASH_AW  packed source addresses; channel i at [i*FLASH_AW +: FLASH_AW].
- ch_psram_dst  in  NUM_CH*PSRAM_AW  packed destination word addresses.
- ch_length  in  NUM_CH*LEN_W  packed byte counts.
- ch_pack  in  NUM_CH  per channel: 0 = replicate byte into both halves, one word per byte; 1 = pack two bytes per word.
- abort  in  1  cancel all pending and active work.
- ch_pending  out  NUM_CH  descriptor latched, not yet finished.
- ch_done  out  NUM_CH  one-cycle pulse on successful completion.
- busy  out  1  any channel pending or active.
- active_ch  out  3  index of the channel being served; 0 when idle.
- flash_dma_enabled  out  1  high while owning the flash/PSRAM ports.
- flash_addr  out  FLASH_AW; flash_req_r_addr  out  1; flash_req_r_next  out  1.
- flash_d_ready  in  1; flash_d_out  in  8.
- psram_w_strobe  out  1; psram_addr  out  PSRAM_AW; psram_d_in  out  16.
- psram_busy  in  1.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0, ch_pending 0, state IDLE.
  - Round-robin pointer selects channel 0 first.
  - Reset mid-transfer abandons the transfer without a completing write.
- Start latching:
  - ch_start[i] while ch_pending[i]=0 copies channel i's descriptor into internal registers and sets ch_pending[i] next cycle.
  - ch_start[i] while ch_pending[i]=1 is ignored.
  - Descriptor inputs are don't-care after latching.
- Default-low pulse outputs each cycle: flash_req_r_addr, flash_req_r_next, psram_w_strobe, ch_done.
- States:
  - IDLE: if any pending and !abort, pick the first pending channel at or after the pointer (wrapping), set active_ch → START.
  - START:
    - length 0: clear pending, pulse ch_done, advance pointer → IDLE; no port activity and flash_dma_enabled stays low.
    - Otherwise: flash_dma_enabled=1, flash_addr=src, pulse flash_req_r_addr, psram_addr=dst-1 → F_LOW.
  - F_LOW: wait flash_d_ready=0 → F_DATA.
  - F_DATA: when flash_d_ready=1, capture flash_d_out and decrement the remaining count.
    - If remaining becomes ≠0, pulse flash_req_r_next in the same cycle.
    - Pack mode, even byte (LSB first): store in the low half and go to F_LOW, unless it was the last byte → WR.
    - All other cases → WR.
  - WR: when psram_busy=0, set psram_d_in and increment psram_addr.
    - Replicate mode: psram_d_in = {b,b}.
    - Pack mode: psram_d_in = {hi,lo}; an odd final byte gives hi=8'h00.
    - Pulse psram_w_strobe → ACK.
  - ACK: wait psram_busy=1. Then remaining≠0 → F_LOW; else → DRAIN.
  - DRAIN: wait psram_busy=0, clear pending, pulse ch_done, pointer = active+1 mod NUM_CH, flash_dma_enabled=0 → IDLE.
- Arithmetic:
  - Address increments wrap modulo 2^AW.
  - Words written = length (replicate) or ceil(length/2) (pack).
- Abort, sampled in any state:
  - Clears all ch_pending in the same cycle.
  - Outside WR/ACK: go directly to IDLE.
  - In WR: suppress the strobe; if a strobe was already issued, go to DRAIN.
  - DRAIN in an aborted transfer gives no ch_done.
- Simultaneous ch_start and abort: abort wins; the start is dropped.
- busy = |ch_pending or state≠IDLE.

Test Plan:
- Ch0 src=0x100000, dst=0x2000, len=3, pack=0; bytes 11,22,33.
  - Expect writes {1111}@0x2000, {2222}@0x2001, {3333}@0x2002.
  - Expect exactly 2 flash_req_r_next pulses, then one ch_done[0].
- Ch1 len=5, pack=1; bytes 01..05.
  - Expect 0x0201@dst, 0x0403@dst+1, 0x0005@dst+2, then ch_done[1].
- Ch0 and ch1 started the same cycle, then ch0 restarted.
  - Expect order ch0, ch1, ch0.
  - Expect active_ch and done pulses to match that order.
- Len=0 on ch1: ch_done[1] within 3 cycles; no flash or PSRAM pulses; flash_dma_enabled never high.
- psram_busy held high for 10 cycles before the first write.
  - No strobe until it drops.
  - Exactly one strobe per word; the count is still correct.
- Abort after 2 of 8 bytes with ch1 pending.
  - Expect no ch_done.
  - Expect ch_pending=0 and busy=0 once psram_busy falls.
  - A new ch1 start after that runs normally.
  - Separately, rst_n pulsed mid-transfer returns all outputs to 0 immediately.
